// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage on the requester side of a 2-read/1-write register file.
// Drives the register-file read ports from the issuing instruction and the write
// port from writeback. Keeps a pending-write scoreboard, forwards same-cycle
// writeback data, stalls issue on hazards, and hands a registered operand bundle
// to execute over a valid/ready handshake.
//
// Ports:
//   clk, async_rst (async, active-high), clk_en (low freezes all state)
//   issue_*        decoded instruction in (valid/ready)
//   rf_rd_*_a/b    register-file read ports (data returns in the same cycle)
//   rf_wr_*        register-file write port, driven from writeback
//   wb_*           writeback result in (always accepted)
//   op_*           registered operand bundle out (valid/ready)
//
// Build option: define REG_ZERO_HARDWIRE_EN to make register 0 read as zero,
// never become pending, and have writes to it dropped.
module regfile_operand_fetch #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  clk_en,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rs_a,
  input  logic [ADDR_WIDTH-1:0] issue_rs_b,
  input  logic                  issue_use_a,
  input  logic                  issue_use_b,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  issue_wr,
  output logic                  rf_rd_en_a,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_a,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_a,
  output logic                  rf_rd_en_b,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_b,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [ADDR_WIDTH-1:0] op_rd,
  output logic                  op_wr
);

  logic [REG_COUNT-1:0]  r_pending;
  logic                  r_op_valid;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [ADDR_WIDTH-1:0] r_op_rd;
  logic                  r_op_wr;

  logic [REG_COUNT-1:0]  w_wb_dec;
  logic [REG_COUNT-1:0]  w_eff_pend;
  logic [REG_COUNT-1:0]  w_set;
  logic                  w_hazard;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_opnd_a;
  logic [DATA_WIDTH-1:0] w_opnd_b;

  // Register-file port drive
  assign rf_rd_en_a   = issue_valid & issue_use_a;
  assign rf_rd_addr_a = issue_rs_a;
  assign rf_rd_en_b   = issue_valid & issue_use_b;
  assign rf_rd_addr_b = issue_rs_b;
`ifdef REG_ZERO_HARDWIRE_EN
  assign rf_wr_en     = wb_valid & clk_en & (wb_addr != '0);
`else
  assign rf_wr_en     = wb_valid & clk_en;
`endif
  assign rf_wr_addr   = wb_addr;
  assign rf_wr_data   = wb_data;

  // A writeback landing this cycle resolves its register's hazard immediately
  always_comb begin
    w_wb_dec = '0;
    if (wb_valid) w_wb_dec[wb_addr] = 1'b1;
    w_eff_pend = r_pending & ~w_wb_dec;
`ifdef REG_ZERO_HARDWIRE_EN
    w_eff_pend[0] = 1'b0;
`endif
  end

  assign w_hazard = (issue_use_a & w_eff_pend[issue_rs_a]) |
                    (issue_use_b & w_eff_pend[issue_rs_b]) |
                    (issue_wr    & w_eff_pend[issue_rd]);

  assign issue_ready = clk_en & ~w_hazard & (~r_op_valid | op_ready);
  assign w_accept    = issue_valid & issue_ready;

  // Operand select: unused -> 0, same-cycle writeback wins over the file
  always_comb begin
    w_opnd_a = '0;
    w_opnd_b = '0;
    if (issue_use_a) w_opnd_a = (wb_valid && (wb_addr == issue_rs_a)) ? wb_data : rf_rd_data_a;
    if (issue_use_b) w_opnd_b = (wb_valid && (wb_addr == issue_rs_b)) ? wb_data : rf_rd_data_b;
`ifdef REG_ZERO_HARDWIRE_EN
    if (issue_rs_a == '0) w_opnd_a = '0;
    if (issue_rs_b == '0) w_opnd_b = '0;
`endif
  end

  // Scoreboard set on an accepted writer
  always_comb begin
    w_set = '0;
    if (w_accept && issue_wr) w_set[issue_rd] = 1'b1;
`ifdef REG_ZERO_HARDWIRE_EN
    w_set[0] = 1'b0;
`endif
  end

  // Scoreboard and output bundle; set is applied after clear so set wins
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_pending  <= '0;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_rd    <= '0;
      r_op_wr    <= 1'b0;
    end else if (clk_en) begin
      r_pending <= (r_pending & ~w_wb_dec) | w_set;
      if (w_accept) begin
        r_op_valid <= 1'b1;
        r_op_a     <= w_opnd_a;
        r_op_b     <= w_opnd_b;
        r_op_rd    <= issue_rd;
        r_op_wr    <= issue_wr;
      end else if (op_ready) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_rd    = r_op_rd;
  assign op_wr    = r_op_wr;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Self-checking bench for regfile_operand_fetch. A behavioural register file
// answers the read ports; a scoreboard queue holds the bundle expected for each
// accepted instruction and is compared whenever execute takes a bundle.
module tb_regfile_operand_fetch;
  localparam int unsigned DW = 64;
  localparam int unsigned RC = 16;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] rd;
    logic          wr;
  } bundle_t;

  logic          clk = 1'b0;
  logic          async_rst, clk_en;
  logic          issue_valid, issue_ready;
  logic [AW-1:0] issue_rs_a, issue_rs_b, issue_rd;
  logic          issue_use_a, issue_use_b, issue_wr;
  logic          rf_rd_en_a, rf_rd_en_b, rf_wr_en;
  logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [DW-1:0] rf_rd_data_a, rf_rd_data_b, rf_wr_data;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          op_valid, op_ready, op_wr;
  logic [DW-1:0] op_a, op_b;
  logic [AW-1:0] op_rd;

  logic [DW-1:0] rf_mem [RC];
  logic          init_mem;
  bundle_t       sb [$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  regfile_operand_fetch #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b),
    .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .issue_rd(issue_rd), .issue_wr(issue_wr),
    .rf_rd_en_a(rf_rd_en_a), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_data_a(rf_rd_data_a),
    .rf_rd_en_b(rf_rd_en_b), .rf_rd_addr_b(rf_rd_addr_b), .rf_rd_data_b(rf_rd_data_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      3:       return 64'h11;
      5:       return 64'h22;
      default: return 64'hA5A5_0000_0000_0000 | 64'(i);
    endcase
  endfunction

  // Behavioural register file: combinational read, posedge write
  assign rf_rd_data_a = rf_mem[rf_rd_addr_a];
  assign rf_rd_data_b = rf_mem[rf_rd_addr_b];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < RC; i++) rf_mem[i] <= init_val(i);
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  function automatic logic [DW-1:0] exp_opnd(input logic use_x, input logic [AW-1:0] rs);
    if (!use_x) return '0;
`ifdef REG_ZERO_HARDWIRE_EN
    if (rs == '0) return '0;
`endif
    if (wb_valid && wb_addr == rs) return wb_data;
    return rf_mem[rs];
  endfunction

  // Scoreboard: compare a consumed bundle, then record the newly accepted one
  always @(negedge clk) begin
    bundle_t got, exp;
    if (!async_rst && clk_en) begin
      if (op_valid && op_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: bundle a=%0h rd=%0d delivered, none expected", op_a, op_rd);
        end else begin
          got = '{a: op_a, b: op_b, rd: op_rd, wr: op_wr};
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_bundle: got a=%0h b=%0h rd=%0d wr=%0b expected a=%0h b=%0h rd=%0d wr=%0b",
                     got.a, got.b, got.rd, got.wr, exp.a, exp.b, exp.rd, exp.wr);
          end
        end
      end
      if (issue_valid && issue_ready)
        sb.push_back('{a: exp_opnd(issue_use_a, issue_rs_a), b: exp_opnd(issue_use_b, issue_rs_b),
                       rd: issue_rd, wr: issue_wr});
    end
  end

  task automatic idle();
    issue_valid = 0; issue_use_a = 0; issue_use_b = 0; issue_wr = 0;
    issue_rs_a = '0; issue_rs_b = '0; issue_rd = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    async_rst = 1; init_mem = 1; clk_en = 1; op_ready = 1; idle();
    tick(); tick();
    init_mem = 0;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0 || op_a !== '0 || op_b !== '0 || op_rd !== '0 || op_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b a=%0h b=%0h rd=%0d wr=%0b expected all 0", op_valid, op_a, op_b, op_rd, op_wr);
    end
    #2 async_rst = 0;
    for (int r = 0; r < RC; r++) begin
      tick(); issue_use_a = 1; issue_rs_a = AW'(r);
      @(negedge clk);
      checks++;
      if (issue_ready !== 1'b1) begin
        errors++; $display("FAIL reset_pending r%0d: issue_ready=%0b expected 1", r, issue_ready);
      end
    end
    tick(); idle();
  endtask

  task automatic test_basic();
    issue_valid = 1; issue_use_a = 1; issue_use_b = 1; issue_rs_a = 3; issue_rs_b = 5; issue_rd = 1;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || rf_rd_en_a !== 1'b1 || rf_rd_addr_a !== 4'd3 || rf_rd_en_b !== 1'b1 || rf_rd_addr_b !== 4'd5) begin
      errors++;
      $display("FAIL basic_issue: ready=%0b en_a=%0b addr_a=%0d en_b=%0b addr_b=%0d expected 1 1 3 1 5",
               issue_ready, rf_rd_en_a, rf_rd_addr_a, rf_rd_en_b, rf_rd_addr_b);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 64'h11 || op_b !== 64'h22 || op_rd !== 4'd1 || op_wr !== 1'b0 || rf_rd_en_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_bundle: v=%0b a=%0h b=%0h rd=%0d wr=%0b en_a=%0b expected 1 11 22 1 0 0",
               op_valid, op_a, op_b, op_rd, op_wr, rf_rd_en_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: op_valid=%0b expected 0", op_valid); end
    tick();
  endtask

  task automatic test_hazard_forward();
    issue_valid = 1; issue_wr = 1; issue_rd = 4;
    @(negedge clk); tick();
    issue_wr = 0; issue_rd = 0; issue_use_a = 1; issue_rs_a = 4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_stall c%0d: issue_ready=%0b expected 0", i, issue_ready); end
      tick();
    end
    wb_valid = 1; wb_addr = 4; wb_data = 64'hAB;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || rf_wr_en !== 1'b1 || rf_wr_addr !== 4'd4 || rf_wr_data !== 64'hAB) begin
      errors++;
      $display("FAIL wb_release: ready=%0b wr_en=%0b addr=%0d data=%0h expected 1 1 4 ab", issue_ready, rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 64'hAB) begin
      errors++; $display("FAIL forward: v=%0b op_a=%0h expected 1 ab", op_valid, op_a);
    end
    tick();
    wb_valid = 1; wb_addr = 9; wb_data = 64'h99; issue_use_a = 1; issue_rs_a = 4;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || rf_wr_en !== 1'b1) begin
      errors++; $display("FAIL wb_nonpending: ready=%0b wr_en=%0b expected 1 1", issue_ready, rf_wr_en);
    end
    tick(); idle(); issue_use_a = 1; issue_rs_a = 9;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL nonpending_r9: issue_ready=%0b expected 1", issue_ready); end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_a;
    op_ready = 0;
    issue_valid = 1; issue_use_a = 1; issue_use_b = 1; issue_rs_a = 1; issue_rs_b = 2; issue_rd = 3;
    @(negedge clk); tick();
    issue_rs_a = 6; issue_rs_b = 8; issue_rd = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (issue_ready !== 1'b0 || op_valid !== 1'b1 || op_a !== init_val(1) || op_b !== init_val(2) || op_rd !== 4'd3) begin
        errors++;
        $display("FAIL hold c%0d: ready=%0b v=%0b a=%0h b=%0h rd=%0d expected 0 1 %0h %0h 3",
                 i, issue_ready, op_valid, op_a, op_b, op_rd, init_val(1), init_val(2));
      end
      tick();
    end
    op_ready = 1;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL hold_release: issue_ready=%0b expected 1", issue_ready); end
    tick();
    exp_a = init_val(6);
    issue_use_b = 0;
    for (int i = 0; i < 3; i++) begin
      issue_rs_a = AW'(10 + i); issue_rd = AW'(i);
      @(negedge clk);
      checks++;
      if (issue_ready !== 1'b1 || op_valid !== 1'b1 || op_a !== exp_a) begin
        errors++;
        $display("FAIL b2b c%0d: ready=%0b v=%0b a=%0h expected 1 1 %0h", i, issue_ready, op_valid, op_a, exp_a);
      end
      exp_a = init_val(10 + i);
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1 || op_a !== init_val(12) || op_b !== '0) begin
      errors++; $display("FAIL b2b_last: v=%0b a=%0h b=%0h expected 1 %0h 0", op_valid, op_a, op_b, init_val(12));
    end
    tick();
  endtask

  task automatic test_same_cycle_set_clear();
    issue_valid = 1; issue_wr = 1; issue_rd = 7;
    @(negedge clk); tick();
    wb_valid = 1; wb_addr = 7; wb_data = 64'h77;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL setclr_issue: issue_ready=%0b expected 1", issue_ready); end
    tick(); idle(); issue_use_a = 1; issue_rs_a = 7;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL set_wins: issue_ready=%0b expected 0", issue_ready); end
    tick();
    wb_valid = 1; wb_addr = 7; wb_data = 64'h78;
    @(negedge clk); tick();
    wb_valid = 0;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL r7_cleared: issue_ready=%0b expected 1", issue_ready); end
    tick(); idle();
  endtask

  task automatic test_clk_en_and_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 10;
    @(negedge clk); tick();
    clk_en = 0; issue_wr = 0; issue_rd = 0; issue_use_a = 1; issue_rs_a = 11;
    wb_valid = 1; wb_addr = 10; wb_data = 64'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (issue_ready !== 1'b0 || rf_wr_en !== 1'b0 || op_valid !== 1'b1 || op_rd !== 4'd10 || op_wr !== 1'b1) begin
        errors++;
        $display("FAIL clk_en_freeze c%0d: ready=%0b wr_en=%0b v=%0b rd=%0d wr=%0b expected 0 0 1 10 1",
                 i, issue_ready, rf_wr_en, op_valid, op_rd, op_wr);
      end
      tick();
    end
    clk_en = 1; idle(); issue_use_a = 1; issue_rs_a = 10;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL clk_en_pending_kept: issue_ready=%0b expected 0", issue_ready); end
    tick();
    idle(); issue_valid = 1; issue_use_a = 1; issue_rs_a = 2; issue_wr = 1; issue_rd = 12;
    @(negedge clk); tick();
    #2;
    async_rst = 1; sb.delete();
    idle(); issue_use_a = 1; issue_rs_a = 10;
    #1;
    checks++;
    if (op_valid !== 1'b0 || op_rd !== '0 || op_a !== '0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: v=%0b rd=%0d a=%0h ready=%0b expected 0 0 0 1", op_valid, op_rd, op_a, issue_ready);
    end
    tick(); #2 async_rst = 0;
    tick(); issue_rs_a = 12;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_r12: issue_ready=%0b expected 1", issue_ready); end
    tick(); issue_valid = 1; issue_rs_a = 10;
    @(negedge clk); tick(); idle();
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1 || op_a !== init_val(10)) begin
      errors++; $display("FAIL no_write_when_frozen: v=%0b a=%0h expected 1 %0h", op_valid, op_a, init_val(10));
    end
    tick();
  endtask

  task automatic test_reg_zero();
    wb_valid = 1; wb_addr = 0; wb_data = 64'hFF;
    issue_valid = 1; issue_use_a = 1; issue_rs_a = 0; issue_wr = 1; issue_rd = 0;
`ifdef REG_ZERO_HARDWIRE_EN
    @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL r0_drop: wr_en=%0b ready=%0b expected 0 1", rf_wr_en, issue_ready);
    end
    tick(); wb_valid = 0;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || op_a !== '0) begin
      errors++; $display("FAIL r0_zero: ready=%0b a=%0h expected 1 0", issue_ready, op_a);
    end
    tick(); idle();
`else
    @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b1 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL r0_write: wr_en=%0b ready=%0b expected 1 1", rf_wr_en, issue_ready);
    end
    tick(); wb_valid = 0;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0 || op_a !== 64'hFF) begin
      errors++; $display("FAIL r0_ordinary: ready=%0b a=%0h expected 0 ff", issue_ready, op_a);
    end
    tick(); wb_valid = 1; wb_addr = 0; wb_data = 64'h100;
    @(negedge clk); tick();
    idle(); wb_valid = 1; wb_addr = 0; wb_data = 64'h101;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 64'h100) begin
      errors++; $display("FAIL r0_forward: v=%0b a=%0h expected 1 100", op_valid, op_a);
    end
    tick(); idle();
`endif
  endtask

  initial begin
    idle(); clk_en = 1; op_ready = 1; async_rst = 1; init_mem = 1;
    test_reset();
    test_basic();
    test_hazard_forward();
    test_back_to_back();
    test_same_cycle_set_clear();
    test_clk_en_and_reset();
    test_reg_zero();
    idle(); op_ready = 1;
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d bundles never delivered", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
